dica_senha_multi: RTL



---
 rtl/dica_senha_if.sv | 32 +++
 rtl/dica_senha_multi.sv | 114 +++++++++++
 2 files changed

// File: rtl/dica_senha_if.sv
// Signal bundle for the higher/lower hint unit: guess entry, secret/mask table,
// 7-segment hint and game status.
interface dica_senha_if #(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter int MAX_TRIES = 7
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic                      ENABLE;
  logic                      CLEAR;
  logic                      ENTER;
  logic [WIDTH-1:0]          TENTATIVA;
  logic [STAGES*WIDTH-1:0]   SECRETS;
  logic [STAGES*WIDTH-1:0]   MASKS;
  logic [0:6]                MENOR_OU_MAIOR;
  logic [SW-1:0]             STAGE;
  logic [TW-1:0]             TRIES_LEFT;
  logic                      ACERTOU;
  logic                      ESGOTOU;

  modport master (
    output ENABLE, CLEAR, ENTER, TENTATIVA, SECRETS, MASKS,
    input  MENOR_OU_MAIOR, STAGE, TRIES_LEFT, ACERTOU, ESGOTOU
  );

  modport slave (
    input  ENABLE, CLEAR, ENTER, TENTATIVA, SECRETS, MASKS,
    output MENOR_OU_MAIOR, STAGE, TRIES_LEFT, ACERTOU, ESGOTOU
  );
endinterface

// File: rtl/dica_senha_multi.sv
// Multi-stage higher/lower hint unit: synchronises the ENTER button, compares each
// confirmed guess with the current stage's masked secret and tracks tries and outcome.
module dica_senha_multi #(
  parameter int WIDTH     = 4,
  parameter int STAGES    = 2,
  parameter int MAX_TRIES = 7
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  dica_senha_if.slave bus
);
  localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);

  localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
  localparam logic [TW-1:0] FULL_TRIES = TW'(MAX_TRIES);
  localparam logic [6:0]    HINT_OFF   = 7'b1111111;
  localparam logic [6:0]    HINT_HIGH  = 7'b1001111;
  localparam logic [6:0]    HINT_LOW   = 7'b1111001;

  typedef enum logic [1:0] {ACTIVE, WIN, LOSE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [TW-1:0] tries_q, tries_d;
  logic [6:0]    hint_q,  hint_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          hist_q,  hist_d;

  logic             pulse;
  logic [WIDTH-1:0] mask_s, guess_m, key_m;
  logic [6:0]       code;
  logic             match;
  int               base;

  // ENTER is asynchronous: two flops for metastability, a third to find the rising edge.
  always_comb begin
    sync1_d = bus.ENTER;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    pulse   = sync2_q & ~hist_q;
  end

  always_comb begin
    base    = int'(stage_q) * WIDTH;
    mask_s  = bus.MASKS[base +: WIDTH];
    guess_m = bus.TENTATIVA & mask_s;
    key_m   = bus.SECRETS[base +: WIDTH] & mask_s;
    match   = (guess_m == key_m);
    if (guess_m > key_m)      code = HINT_HIGH;
    else if (guess_m < key_m) code = HINT_LOW;
    else                      code = HINT_OFF;
  end

  // NOTE: every next-state signal gets its hold value first, so no path through
  // this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    tries_d = tries_q;
    hint_d  = hint_q;

    if (bus.CLEAR) begin
      state_d = ACTIVE;
      stage_d = '0;
      tries_d = FULL_TRIES;
      hint_d  = HINT_OFF;
    end else if (pulse && bus.ENABLE && state_q == ACTIVE) begin
      if (tries_q != '0) tries_d = tries_q - TW'(1);
      if (match && stage_q == LAST_STAGE) begin
        state_d = WIN;
        hint_d  = HINT_OFF;
      end else if (tries_q <= TW'(1)) begin
        // Out of tries: a non-final match still loses and the hint keeps this guess.
        state_d = LOSE;
        hint_d  = code;
      end else if (match) begin
        stage_d = stage_q + SW'(1);
        hint_d  = HINT_OFF;
      end else begin
        hint_d  = code;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all of them update together
  // from the values present before the edge.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ACTIVE;
      stage_q <= '0;
      tries_q <= FULL_TRIES;
      hint_q  <= HINT_OFF;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      tries_q <= tries_d;
      hint_q  <= hint_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign bus.MENOR_OU_MAIOR = hint_q;
  assign bus.STAGE          = stage_q;
  assign bus.TRIES_LEFT     = tries_q;
  assign bus.ACERTOU        = (state_q == WIN);
  assign bus.ESGOTOU        = (state_q == LOSE);
endmodule
